// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and defaults for the I/D memory bus arbiter.
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } arb_owner_t;

    localparam int STARVE_LIMIT_DEF = 4;

endpackage

// File: rtl/mem_bus_arbiter.sv
// Shares one external memory port between instruction fetch (I) and data access (D).
// D wins by default; a saturating starvation counter forces an I grant.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_valid,
    input  logic [AW-1:0]   i_addr,
    output logic            i_data_ok,
    output logic [DW-1:0]   i_rdata,
    output logic            i_wait,
    input  logic            d_valid,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW/8-1:0] d_strobe,
    input  logic [DW-1:0]   d_wdata,
    output logic            d_data_ok,
    output logic [DW-1:0]   d_rdata,
    output logic            d_wait,
    output logic            m_req,
    output logic [AW-1:0]   m_addr,
    output logic [DW/8-1:0] m_strobe,
    output logic [DW-1:0]   m_wdata,
    input  logic            m_addr_ok,
    input  logic            m_data_ok,
    input  logic [DW-1:0]   m_rdata
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);

    arb_state_t state;
    arb_owner_t owner;
    logic [CW-1:0] starve_cnt;
    logic abort;

    logic own_valid;
    logic done;
    logic grant_d;

    always_comb begin
        own_valid = (owner == OWN_D) ? d_valid : i_valid;
        done      = (state == REQ && m_addr_ok && m_data_ok) || (state == RESP && m_data_ok);
        grant_d   = d_valid && !(i_valid && starve_cnt == CW'(STARVE_LIMIT));
        m_req     = (state == REQ);
        // A flushed owner (valid low now or at any point since grant) never sees its data_ok.
        i_data_ok = done && owner == OWN_I && i_valid && !abort;
        d_data_ok = done && owner == OWN_D && d_valid && !abort;
        i_rdata   = m_rdata;
        d_rdata   = m_rdata;
        i_wait    = i_valid && !i_data_ok;
        d_wait    = d_valid && !d_data_ok;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            owner      <= OWN_I;
            starve_cnt <= '0;
            abort      <= 1'b0;
            m_addr     <= '0;
            m_strobe   <= '0;
            m_wdata    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    abort <= 1'b0;
                    if (!i_valid)
                        starve_cnt <= '0;
                    if (i_valid || d_valid) begin
                        state <= REQ;
                        if (grant_d) begin
                            owner    <= OWN_D;
                            m_addr   <= d_addr;
                            m_strobe <= d_strobe;
                            m_wdata  <= d_wdata;
                            if (i_valid && starve_cnt != CW'(STARVE_LIMIT))
                                starve_cnt <= starve_cnt + CW'(1);
                        end else begin
                            owner      <= OWN_I;
                            m_addr     <= i_addr;
                            m_strobe   <= '0;
                            m_wdata    <= '0;
                            starve_cnt <= '0;
                        end
                    end
                end
                REQ: begin
                    if (!own_valid)
                        abort <= 1'b1;
                    if (m_addr_ok)
                        state <= m_data_ok ? IDLE : RESP;
                end
                RESP: begin
                    if (!own_valid)
                        abort <= 1'b1;
                    if (m_data_ok)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: the bus side is driven cycle by cycle from the stimulus.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_valid;
    logic [31:0] i_addr;
    logic        i_data_ok;
    logic [31:0] i_rdata;
    logic        i_wait;
    logic        d_valid;
    logic [31:0] d_addr;
    logic [3:0]  d_strobe;
    logic [31:0] d_wdata;
    logic        d_data_ok;
    logic [31:0] d_rdata;
    logic        d_wait;
    logic        m_req;
    logic [31:0] m_addr;
    logic [3:0]  m_strobe;
    logic [31:0] m_wdata;
    logic        m_addr_ok;
    logic        m_data_ok;
    logic [31:0] m_rdata;

    int n_chk  = 0;
    int n_fail = 0;

    bit exp_d [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    always #5 clk = ~clk;

    mem_bus_arbiter #(.AW(32), .DW(32), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .i_valid(i_valid), .i_addr(i_addr), .i_data_ok(i_data_ok), .i_rdata(i_rdata), .i_wait(i_wait),
        .d_valid(d_valid), .d_addr(d_addr), .d_strobe(d_strobe), .d_wdata(d_wdata),
        .d_data_ok(d_data_ok), .d_rdata(d_rdata), .d_wait(d_wait),
        .m_req(m_req), .m_addr(m_addr), .m_strobe(m_strobe), .m_wdata(m_wdata),
        .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are then driven and outputs sampled before the falling edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; i_valid = 0; i_addr = 0; d_valid = 0; d_addr = 0; d_strobe = 0; d_wdata = 0;
        m_addr_ok = 0; m_data_ok = 0; m_rdata = 0;
        #1;
        chk("rst_m_req", m_req, 0);
        chk("rst_i_ok", i_data_ok, 0);
        chk("rst_d_ok", d_data_ok, 0);
        chk("rst_m_addr", m_addr, 0);
        chk("rst_m_strobe", m_strobe, 0);
        repeat (2) tick();
        reset = 1'b1;
        tick();

        // 1: lone I read, addr_ok at +1, data_ok at +3
        i_valid = 1; i_addr = 32'h1000;
        #1;
        chk("t1_req_lat", m_req, 0);
        chk("t1_i_wait", i_wait, 1);
        tick();
        chk("t1_m_req", m_req, 1);
        chk("t1_m_addr", m_addr, 32'h1000);
        chk("t1_m_strobe", m_strobe, 0);
        m_addr_ok = 1;
        tick();
        m_addr_ok = 0;
        #1 chk("t1_resp_req", m_req, 0);
        tick();
        m_data_ok = 1; m_rdata = 32'hDEADBEEF;
        #1;
        chk("t1_i_ok", i_data_ok, 1);
        chk("t1_i_rdata", i_rdata, 32'hDEADBEEF);
        chk("t1_i_wait", i_wait, 0);
        chk("t1_d_ok", d_data_ok, 0);
        tick();
        m_data_ok = 0; i_valid = 0;
        #1 chk("t1_idle_ok", i_data_ok, 0);

        // 2: I and D together, D store wins, then I
        i_valid = 1; i_addr = 32'h1004;
        d_valid = 1; d_addr = 32'h2000; d_strobe = 4'hF; d_wdata = 32'h55;
        tick();
        chk("t2_d_addr", m_addr, 32'h2000);
        chk("t2_d_strobe", m_strobe, 4'hF);
        chk("t2_d_wdata", m_wdata, 32'h55);
        m_addr_ok = 1;
        tick();
        m_addr_ok = 0; m_data_ok = 1;
        #1;
        chk("t2_d_ok", d_data_ok, 1);
        chk("t2_i_ok_n", i_data_ok, 0);
        chk("t2_i_wait", i_wait, 1);
        tick();
        m_data_ok = 0; d_valid = 0; d_strobe = 0;
        #1 chk("t2_gap", m_req, 0);
        tick();
        chk("t2_i_addr", m_addr, 32'h1004);
        chk("t2_i_strobe", m_strobe, 0);
        m_addr_ok = 1; m_data_ok = 1; m_rdata = 32'h11;
        #1 chk("t2_i_ok", i_data_ok, 1);
        tick();
        m_addr_ok = 0; m_data_ok = 0; i_valid = 0;

        // 3: D held continuously with I pending -> D,D,D,D,I,D
        i_valid = 1; i_addr = 32'h4000;
        d_valid = 1; d_addr = 32'h3000; d_strobe = 4'h0;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk($sformatf("t3_req%0d", k), m_req, 1);
            chk($sformatf("t3_addr%0d", k), m_addr, exp_d[k] ? 32'h3000 : 32'h4000);
            m_addr_ok = 1; m_data_ok = 1; m_rdata = 32'(k);
            #1;
            chk($sformatf("t3_own_ok%0d", k), exp_d[k] ? d_data_ok : i_data_ok, 1);
            chk($sformatf("t3_oth_ok%0d", k), exp_d[k] ? i_data_ok : d_data_ok, 0);
            tick();
            m_addr_ok = 0; m_data_ok = 0;
        end
        i_valid = 0; d_valid = 0;
        tick();

        // 4: D read with addr_ok and data_ok in the same cycle
        d_valid = 1; d_addr = 32'h2040; d_strobe = 4'h0;
        tick();
        chk("t4_strobe", m_strobe, 0);
        m_addr_ok = 1; m_data_ok = 1; m_rdata = 32'hCAFEF00D;
        #1;
        chk("t4_d_ok", d_data_ok, 1);
        chk("t4_d_rdata", d_rdata, 32'hCAFEF00D);
        chk("t4_d_wait", d_wait, 0);
        tick();
        m_addr_ok = 0; m_data_ok = 0; d_valid = 0;
        #1 chk("t4_idle", m_req, 0);
        tick();

        // 5: I flushed in RESP; re-raised valid must not take the stale response
        i_valid = 1; i_addr = 32'h1008;
        tick();
        m_addr_ok = 1;
        tick();
        m_addr_ok = 0; i_valid = 0;
        tick();
        i_valid = 1; i_addr = 32'h1004; m_data_ok = 1; m_rdata = 32'hBAD;
        #1 chk("t5_abort_ok", i_data_ok, 0);
        tick();
        m_data_ok = 0;
        #1 chk("t5_gap", m_req, 0);
        tick();
        chk("t5_new_addr", m_addr, 32'h1004);
        m_addr_ok = 1;
        tick();
        m_addr_ok = 0; m_data_ok = 1; m_rdata = 32'h600D;
        #1;
        chk("t5_new_ok", i_data_ok, 1);
        chk("t5_new_rdata", i_rdata, 32'h600D);
        tick();
        m_data_ok = 0; i_valid = 0;
        tick();

        // 6: reset asserted in RESP
        d_valid = 1; d_addr = 32'h2080; d_strobe = 4'h3; d_wdata = 32'h77;
        tick();
        m_addr_ok = 1;
        tick();
        m_addr_ok = 0;
        #1 reset = 1'b0;
        #1;
        chk("t6_m_req", m_req, 0);
        chk("t6_m_addr", m_addr, 0);
        chk("t6_m_strobe", m_strobe, 0);
        d_valid = 0; d_strobe = 0;
        #1 reset = 1'b1;
        tick();
        m_data_ok = 1; m_rdata = 32'h99;
        #1;
        chk("t6_d_ok", d_data_ok, 0);
        chk("t6_i_ok", i_data_ok, 0);
        chk("t6_idle", m_req, 0);
        tick();
        m_data_ok = 0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
